// File: rtl/page_dispatcher_pkg.sv
// Shared defaults, state encoding and parameter sanity helpers for the page dispatcher.
package page_dispatcher_pkg;

  localparam int PD_NUM_PARSER = 6;
  localparam int PD_DATA_W     = 144;
  localparam int PD_POS_W      = 16;
  localparam int PD_ADDR_W     = 17;
  localparam int PD_GARB_W     = 2;
  localparam int PD_SEQ_W      = 8;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } pd_state_t;

  function automatic bit pd_is_onehot(input logic [15:0] v);
    return (v != 16'd0) && ((v & (v - 16'd1)) == 16'd0);
  endfunction

endpackage

// File: rtl/page_dispatcher_rr_arbiter.sv
// Round-robin one-hot arbiter: searches upward from the bit after base, wrapping to 0.
module rr_arbiter #(
  parameter int N = 6
) (
  input  logic [N-1:0] i_req,
  input  logic [N-1:0] i_base,
  output logic [N-1:0] o_grant
);

  logic w_found;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    for (int b = 0; b < N; b++) begin
      if (i_base[b]) begin
        // k == N lands back on the base itself, so it is considered last
        for (int k = 1; k <= N; k++) begin
          if (!w_found && i_req[(b + k) % N]) begin
            o_grant[(b + k) % N] = 1'b1;
            w_found = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/page_dispatcher.sv
// Pops pages from a show-ahead FIFO and hands each to one parser chosen round-robin.
// state    | meaning
// EMPTY    | no page held in the output register
// FULL     | page held, valid_out points at its parser until accepted
module page_dispatcher
  import page_dispatcher_pkg::*;
#(
  parameter int NUM_PARSER = PD_NUM_PARSER,
  parameter int DATA_W     = PD_DATA_W,
  parameter int POS_W      = PD_POS_W,
  parameter int ADDR_W     = PD_ADDR_W,
  parameter int GARB_W     = PD_GARB_W,
  parameter int SEQ_W      = PD_SEQ_W,
  parameter logic [NUM_PARSER-1:0] BASE_INIT = NUM_PARSER'(1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     data_in,
  input  logic [POS_W-1:0]      position_in,
  input  logic [ADDR_W-1:0]     address_in,
  input  logic [GARB_W-1:0]     garbage_in,
  input  logic                  lit_flag_in,
  input  logic                  valid_in,
  output logic                  rdreq,
  input  logic [NUM_PARSER-1:0] ready,
  input  logic [NUM_PARSER-1:0] parser_en,
  input  logic                  stop,
  output logic [DATA_W-1:0]     data_out,
  output logic [POS_W-1:0]      position_out,
  output logic [ADDR_W-1:0]     address_out,
  output logic [GARB_W-1:0]     garbage_out,
  output logic                  lit_flag_out,
  output logic [SEQ_W-1:0]      seq_out,
  output logic [NUM_PARSER-1:0] valid_out,
  output logic                  idle
);

  if (NUM_PARSER < 2 || NUM_PARSER > 16 || !pd_is_onehot(16'(BASE_INIT))) begin : g_bad_param
    $fatal(1, "page_dispatcher: NUM_PARSER must be 2..16 and BASE_INIT one-hot");
  end

  pd_state_t             r_state;
  logic                  r_stop_q;
  logic                  r_idle;
  logic [NUM_PARSER-1:0] r_base;
  logic [NUM_PARSER-1:0] r_valid_out;
  logic [SEQ_W-1:0]      r_seq_cnt;
  logic [SEQ_W-1:0]      r_seq_out;
  logic [DATA_W-1:0]     r_data;
  logic [POS_W-1:0]      r_pos;
  logic [ADDR_W-1:0]     r_addr;
  logic [GARB_W-1:0]     r_garb;
  logic                  r_lit;

  logic [NUM_PARSER-1:0] w_eligible;
  logic [NUM_PARSER-1:0] w_grant;
  logic                  w_full;
  logic                  w_xfer;
  logic                  w_load;
  logic                  w_next_full;

  assign w_eligible = ready & parser_en;
  assign w_full     = (r_state == ST_FULL);
  // r_valid_out is the held target while FULL and zero otherwise
  assign w_xfer      = w_full & (|(r_valid_out & ready));
  assign w_load      = rst_n & valid_in & ~r_stop_q & (|w_eligible) & (~w_full | w_xfer);
  assign w_next_full = w_load | (w_full & ~w_xfer);

  rr_arbiter #(.N(NUM_PARSER)) u_rr_arbiter (
    .i_req   (w_eligible),
    .i_base  (r_base),
    .o_grant (w_grant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_EMPTY;
      r_stop_q    <= 1'b0;
      r_idle      <= 1'b0;
      r_base      <= BASE_INIT;
      r_valid_out <= '0;
      r_seq_cnt   <= '0;
      r_seq_out   <= '0;
      r_data      <= '0;
      r_pos       <= '0;
      r_addr      <= '0;
      r_garb      <= '0;
      r_lit       <= 1'b0;
    end else begin
      r_stop_q <= stop;
      r_idle   <= stop & ~w_next_full;
      if (w_load) begin
        r_state     <= ST_FULL;
        r_valid_out <= w_grant;
        r_base      <= w_grant;
        r_seq_out   <= r_seq_cnt;
        r_seq_cnt   <= r_seq_cnt + SEQ_W'(1);
        r_data      <= data_in;
        r_pos       <= position_in;
        r_addr      <= address_in;
        r_garb      <= garbage_in;
        r_lit       <= lit_flag_in;
      end else if (w_xfer) begin
        r_state     <= ST_EMPTY;
        r_valid_out <= '0;
      end
    end
  end

  assign rdreq        = w_load;
  assign valid_out    = r_valid_out;
  assign idle         = r_idle;
  assign seq_out      = r_seq_out;
  assign data_out     = r_data;
  assign position_out = r_pos;
  assign address_out  = r_addr;
  assign garbage_out  = r_garb;
  assign lit_flag_out = r_lit;

endmodule

// File: doc/page_dispatcher.md
PAGE_DISPATCHER -- requirements
Module: page_dispatcher

Interface
REQ-001 Parameter NUM_PARSER, default 6, number of parser channels (2..16).
REQ-002 Parameter DATA_W, default 144, page payload width; POS_W default 16, ADDR_W default 17, GARB_W default 2.
REQ-003 Parameter SEQ_W, default 8, width of the page sequence tag.
REQ-004 Parameter BASE_INIT, default one-hot bit 0, initial round-robin base; it SHALL be one-hot and elaboration SHALL fail otherwise.
REQ-005 clk  in  1  sole clock; all state is updated on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 data_in/position_in/address_in/garbage_in/lit_flag_in  in  DATA_W/POS_W/ADDR_W/GARB_W/1  page from show-ahead FIFO.
REQ-008 valid_in  in  1  FIFO non-empty; the head page is present on the *_in ports.
REQ-009 rdreq  out  1  pops the FIFO head in the same cycle.
REQ-010 ready  in  NUM_PARSER  parser i accepts a page in any cycle where ready[i]=1 and valid_out[i]=1.
REQ-011 parser_en  in  NUM_PARSER  mode mask; disabled parsers never receive new pages.
REQ-012 stop  in  1  halts new dispatch; the page already held still drains.
REQ-013 data_out/position_out/address_out/garbage_out/lit_flag_out  out  as inputs  registered page.
REQ-014 seq_out  out  SEQ_W  sequence tag of the held page.
REQ-015 valid_out  out  NUM_PARSER  one-hot target of the held page, otherwise zero.
REQ-016 idle  out  1  high when stop is registered and no page is held.

Function
REQ-017 stop SHALL be registered once (stop_q); all gating uses stop_q.
REQ-018 eligible = ready & parser_en; grant = round-robin one-hot over eligible, searching upward from the bit after base and wrapping at NUM_PARSER-1 to 0.
REQ-019 Two states: EMPTY (no page held) and FULL (page held in the output register).
REQ-020 xfer = FULL & |(valid_out & ready).
REQ-021 load = valid_in & ~stop_q & (eligible != 0) & (EMPTY | xfer); rdreq SHALL equal load.
REQ-022 On load: capture the page, target <= grant, base <= grant, seq_out <= seq_cnt, seq_cnt <= seq_cnt+1 mod 2^SEQ_W; state becomes FULL.
REQ-023 On xfer without load, state becomes EMPTY; on xfer with load, state stays FULL with the new page (back-to-back, one page per cycle).
REQ-024 In FULL without xfer, payload, target and seq_out SHALL hold, even if ready[target] drops or parser_en[target] is cleared.
REQ-025 valid_out = FULL ? target : 0; it SHALL never have more than one bit set.
REQ-026 Latency: a page is presented on the outputs one cycle after the cycle in which rdreq is high.
REQ-027 base SHALL change only on load; with no eligible parser or valid_in=0, base and seq_cnt hold.
REQ-028 stop_q=1 SHALL force rdreq=0 in the same cycle; a held page still completes.
REQ-029 idle = stop_q & EMPTY.

Reset
REQ-030 While rst_n=0: state EMPTY, valid_out=0, rdreq=0, idle=0, base=BASE_INIT, seq_cnt=0, seq_out=0, payload=0, stop_q=0.
REQ-031 A reset asserted mid-transfer SHALL discard the held page with no partial output; the first page after reset carries seq 0.

Structure
REQ-032 Shared package: parameter defaults, a one-hot check function and the state encoding.
REQ-033 One sub-module, rr_arbiter (req, base -> one-hot grant, purely combinational), instantiated once.

Verification
REQ-034 Reset base=000001, ready=111111, en=111111, 4 pages valid -> valid_out 000010, 000100, 001000, 010000 on consecutive cycles; seq 0..3.
REQ-035 Held page to parser 2, ready[2]=0 for 5 cycles -> valid_out=000100 stable, rdreq=0, payload unchanged; on ready[2]=1 -> xfer, next page loaded in the same cycle.
REQ-036 en=101010, ready=111111 -> only bits 1, 3, 5 are granted, in rotation.
REQ-037 stop raised while FULL -> rdreq=0 from the next cycle, held page drains, idle=1 one cycle after xfer.
REQ-038 SEQ_W=2, 6 pages -> seq_out 0,1,2,3,0,1.
REQ-039 rst_n low while FULL -> valid_out=0 immediately (asynchronous); after release, first page gets seq 0 and target 000010.
